// File: rtl/cache_flush_walker_pkg.sv
// Shared types for the cache flush/invalidate walker.
package cache_flush_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WB,
        CLEAR,
        DONE
    } flushstate_t;

endpackage

// File: rtl/cache_flush_walker_if.sv
// Command, tag-status and writeback handshake signals between the flush walker and the cache.
interface cache_flush_walker_if #(
    parameter int unsigned NUMWAYS = 4,
    parameter int unsigned SETLEN  = 7
);
    logic               FlushCache;
    logic               FlushInvalidate;
    logic               FlushAbort;
    logic [NUMWAYS-1:0] ValidWay;
    logic [NUMWAYS-1:0] DirtyWay;
    logic               WriteBackAck;
    logic               FlushAdrSel;
    logic [SETLEN-1:0]  FlushAdr;
    logic [NUMWAYS-1:0] FlushWay;
    logic               WriteBackReq;
    logic               ClearDirty;
    logic               ClearValid;
    logic               FlushBusy;
    logic               FlushDone;

    // Walker side
    modport master (
        input  FlushCache, FlushInvalidate, FlushAbort, ValidWay, DirtyWay, WriteBackAck,
        output FlushAdrSel, FlushAdr, FlushWay, WriteBackReq, ClearDirty, ClearValid,
               FlushBusy, FlushDone
    );

    // Cache / bus side
    modport slave (
        output FlushCache, FlushInvalidate, FlushAbort, ValidWay, DirtyWay, WriteBackAck,
        input  FlushAdrSel, FlushAdr, FlushWay, WriteBackReq, ClearDirty, ClearValid,
               FlushBusy, FlushDone
    );
endinterface

// File: rtl/cache_flush_walker_counter.sv
// Set/way position counter for the flush walk; way index is the fast-moving digit.
module flush_counter #(
    parameter int unsigned NUMWAYS = 4,
    parameter int unsigned SETLEN  = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic                       advance,
    output logic [SETLEN-1:0]          setIdx,
    output logic [$clog2(NUMWAYS)-1:0] wayIdx,
    output logic                       last
);
    localparam int unsigned WAYBITS = $clog2(NUMWAYS);

    // Last way of the last set: the walk stops here instead of wrapping.
    assign last = (wayIdx == '1) && (setIdx == '1);

    // Step way index, carrying into the set index on wrap to way 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            setIdx <= '0;
            wayIdx <= '0;
        end else if (init) begin
            setIdx <= '0;
            wayIdx <= '0;
        end else if (advance && !last) begin
            wayIdx <= wayIdx + WAYBITS'(1);
            if (wayIdx == '1) begin
                setIdx <= setIdx + SETLEN'(1);
            end
        end
    end
endmodule

// File: rtl/cache_flush_walker.sv
// Walks every set/way of the cache, writing back dirty lines and clearing dirty/valid bits.
module cache_flush_walker
    import cache_flush_pkg::*;
#(
    parameter int unsigned NUMWAYS  = 4,
    parameter int unsigned NUMLINES = 128,
    parameter int unsigned SETLEN   = 7
) (
    input logic                  clk,
    input logic                  reset,
    cache_flush_walker_if.master bus
);
    localparam int unsigned       WAYBITS = $clog2(NUMWAYS);
    localparam logic [SETLEN-1:0] LASTSET = SETLEN'(NUMLINES - 1);

    flushstate_t          state, nextState;
    logic                 InvMode, nextInvMode;
    logic                 abortPend, nextAbortPend;
    logic                 wasDirty, nextWasDirty;
    logic                 cntInit, cntAdvance, cntLast, lastLine;
    logic [SETLEN-1:0]    setIdx;
    logic [WAYBITS-1:0]   wayIdx;
    logic [NUMWAYS-1:0]   wayOneHot;
    logic                 dirtyHit, validHit;

    flush_counter #(
        .NUMWAYS (NUMWAYS),
        .SETLEN  (SETLEN)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .init    (cntInit),
        .advance (cntAdvance),
        .setIdx  (setIdx),
        .wayIdx  (wayIdx),
        .last    (cntLast)
    );

    assign wayOneHot    = NUMWAYS'(1) << wayIdx;
    assign lastLine     = cntLast && (setIdx == LASTSET);
    assign dirtyHit     = |(bus.DirtyWay & wayOneHot);
    assign validHit     = |(bus.ValidWay & wayOneHot);
    assign bus.FlushAdr = setIdx;
    assign bus.FlushWay = wayOneHot;

    // State and per-walk flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            InvMode   <= 1'b0;
            abortPend <= 1'b0;
            wasDirty  <= 1'b0;
        end else begin
            state     <= nextState;
            InvMode   <= nextInvMode;
            abortPend <= nextAbortPend;
            wasDirty  <= nextWasDirty;
        end
    end

    // Next-state decode and per-state outputs.
    always_comb begin
        nextState        = state;
        nextInvMode      = InvMode;
        nextAbortPend    = abortPend;
        nextWasDirty     = wasDirty;
        cntInit          = 1'b0;
        cntAdvance       = 1'b0;
        bus.FlushAdrSel  = 1'b0;
        bus.WriteBackReq = 1'b0;
        bus.ClearDirty   = 1'b0;
        bus.ClearValid   = 1'b0;
        bus.FlushDone    = 1'b0;
        bus.FlushBusy    = (state != IDLE);

        case (state)
            IDLE: begin
                if (bus.FlushCache) begin
                    nextInvMode   = bus.FlushInvalidate;
                    nextAbortPend = 1'b0;
                    cntInit       = 1'b1;
                    nextState     = READ;
                end
            end
            READ: begin
                bus.FlushAdrSel = 1'b1;
                nextState       = bus.FlushAbort ? IDLE : CHECK;
            end
            CHECK: begin
                bus.FlushAdrSel = 1'b1;
                if (bus.FlushAbort) begin
                    nextState = IDLE;
                end else if (dirtyHit) begin
                    nextWasDirty = 1'b1;
                    nextState    = WB;
                end else if (InvMode && validHit) begin
                    nextWasDirty = 1'b0;
                    nextState    = CLEAR;
                end else if (lastLine) begin
                    nextState = DONE;
                end else begin
                    cntAdvance = 1'b1;
                    nextState  = READ;
                end
            end
            WB: begin
                // An abort here only ends the walk after the handshake and clear complete.
                bus.FlushAdrSel  = 1'b1;
                bus.WriteBackReq = 1'b1;
                if (bus.FlushAbort) begin
                    nextAbortPend = 1'b1;
                end
                if (bus.WriteBackAck) begin
                    nextState = CLEAR;
                end
            end
            CLEAR: begin
                bus.FlushAdrSel = 1'b1;
                bus.ClearDirty  = wasDirty;
                bus.ClearValid  = InvMode;
                if (abortPend || bus.FlushAbort) begin
                    nextState = IDLE;
                end else if (lastLine) begin
                    nextState = DONE;
                end else begin
                    cntAdvance = 1'b1;
                    nextState  = READ;
                end
            end
            DONE: begin
                bus.FlushDone = 1'b1;
                nextState     = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_flush_walker.sv
// Scoreboard bench for cache_flush_walker with a 4-set, 2-way cache model.
module tb_cache_flush_walker;
    localparam int NW = 2;
    localparam int NL = 4;
    localparam int SL = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cache_flush_walker_if #(.NUMWAYS(NW), .SETLEN(SL)) bus ();

    cache_flush_walker #(
        .NUMWAYS  (NW),
        .NUMLINES (NL),
        .SETLEN   (SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [NW-1:0] validMem [NL];
    logic [NW-1:0] dirtyMem [NL];
    logic [SL-1:0] rdAdr;

    int compared = 0;
    int mismatched = 0;
    int unsigned cyc = 0;
    int unsigned startCyc = 0;
    int ackDelay = 3;
    int wbCnt = 0;
    bit prevSel = 1'b0;
    int prevCode = 0;

    int expVisit[$], obsVisit[$];
    int expWb[$], obsWb[$];
    int expClr[$], obsClr[$];
    int expDone[$], obsDone[$];

    // Tag arrays deliver status one cycle after the address.
    always @(posedge clk or posedge reset)
        if (reset) rdAdr <= '0;
        else       rdAdr <= bus.FlushAdr;

    assign bus.ValidWay = validMem[rdAdr];
    assign bus.DirtyWay = dirtyMem[rdAdr];

    always @(posedge clk) cyc++;

    function automatic int code(input logic [SL-1:0] a, input logic [NW-1:0] w);
        return int'(a) * 4 + int'(w);
    endfunction

    // Monitor: record observed events, apply clears to the model, answer writebacks.
    always @(negedge clk) begin : mon
        int c;
        if (reset) begin
            prevSel = 1'b0;
            wbCnt = 0;
            bus.WriteBackAck = 1'b0;
        end else begin
            c = code(bus.FlushAdr, bus.FlushWay);
            if (bus.FlushAdrSel && (!prevSel || c != prevCode)) obsVisit.push_back(c);
            prevSel = bus.FlushAdrSel;
            prevCode = c;
            if (bus.WriteBackReq) obsWb.push_back(c);
            if (bus.ClearDirty || bus.ClearValid) begin
                obsClr.push_back((bus.ClearDirty ? 32 : 0) + (bus.ClearValid ? 16 : 0) + c);
                if (bus.ClearDirty) dirtyMem[bus.FlushAdr] &= ~bus.FlushWay;
                if (bus.ClearValid) validMem[bus.FlushAdr] &= ~bus.FlushWay;
            end
            if (bus.FlushDone) obsDone.push_back(int'(cyc - startCyc));
            if (bus.WriteBackReq) begin
                wbCnt++;
                bus.WriteBackAck = (ackDelay > 0) && (wbCnt == ackDelay);
            end else begin
                wbCnt = 0;
                bus.WriteBackAck = 1'b0;
            end
        end
    end

    task automatic clear_queues();
        expVisit.delete(); obsVisit.delete();
        expWb.delete();    obsWb.delete();
        expClr.delete();   obsClr.delete();
        expDone.delete();  obsDone.delete();
    endtask

    task automatic set_mem(input logic [NW-1:0] v, input logic [NW-1:0] d);
        for (int s = 0; s < NL; s++) begin
            validMem[s] = v;
            dirtyMem[s] = d;
        end
    endtask

    // Reference walk: visit order, writeback cycles, clear pulses and FlushDone latency.
    task automatic expect_walk(input bit inv, input int ad);
        int lat = 0;
        for (int s = 0; s < NL; s++) begin
            for (int w = 0; w < NW; w++) begin
                int c;
                c = s * 4 + (1 << w);
                expVisit.push_back(c);
                lat += 2;
                if (dirtyMem[s][w]) begin
                    repeat (ad) expWb.push_back(c);
                    expClr.push_back(32 + (inv ? 16 : 0) + c);
                    lat += ad + 1;
                end else if (inv && validMem[s][w]) begin
                    expClr.push_back(16 + c);
                    lat += 1;
                end
            end
        end
        expDone.push_back(lat);
    endtask

    task automatic start_flush(input bit inv);
        @(negedge clk);
        bus.FlushInvalidate = inv;
        bus.FlushCache = 1'b1;
        startCyc = cyc + 1;
        @(negedge clk);
        bus.FlushCache = 1'b0;
        bus.FlushInvalidate = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.FlushBusy) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.FlushCache = 1'b0;
        bus.FlushInvalidate = 1'b0;
        bus.FlushAbort = 1'b0;
        bus.WriteBackAck = 1'b0;
        set_mem('0, '0);
        #1 reset = 1'b1;
        #1;
        compared++;
        if ({bus.FlushAdrSel, bus.WriteBackReq, bus.ClearDirty, bus.ClearValid,
             bus.FlushBusy, bus.FlushDone} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.FlushAdrSel, bus.WriteBackReq,
                     bus.ClearDirty, bus.ClearValid, bus.FlushBusy, bus.FlushDone});
        end
        compared++;
        if (bus.FlushAdr !== 2'd0 || bus.FlushWay !== 2'b01) begin
            mismatched++;
            $display("FAIL reset_pos: got adr=%0d way=%b want adr=0 way=01", bus.FlushAdr, bus.FlushWay);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_walk();
        bit ok;
        clear_queues();
        set_mem('0, '0);
        ackDelay = 3;
        expect_walk(1'b0, ackDelay);
        start_flush(1'b0);
        wait_idle(200, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL clean_timeout: busy=%b want 0", bus.FlushBusy); end
        while (expVisit.size() != 0) begin
            int e, o;
            e = expVisit.pop_front();
            o = (obsVisit.size() != 0) ? obsVisit.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL clean_visit: got %0d want %0d", o, e); end
        end
        compared++;
        if (obsWb.size() != 0) begin mismatched++; $display("FAIL clean_wb: got %0d reqs want 0", obsWb.size()); end
        compared++;
        if (obsDone.size() != 1 || obsDone[0] != expDone[0]) begin
            mismatched++;
            $display("FAIL clean_done: got %0d pulses first=%0d want 1 at %0d", obsDone.size(),
                     (obsDone.size() != 0) ? obsDone[0] : -1, expDone[0]);
        end
    endtask

    task automatic test_dirty_wb();
        bit ok;
        clear_queues();
        set_mem('1, '0);
        dirtyMem[2] = 2'b10;
        ackDelay = 3;
        expect_walk(1'b0, ackDelay);
        start_flush(1'b0);
        wait_idle(200, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL dirty_timeout: busy=%b want 0", bus.FlushBusy); end
        while (expWb.size() != 0) begin
            int e, o;
            e = expWb.pop_front();
            o = (obsWb.size() != 0) ? obsWb.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL dirty_wb: got %0d want %0d", o, e); end
        end
        compared++;
        if (obsWb.size() != 0) begin mismatched++; $display("FAIL dirty_wb_extra: got %0d extra", obsWb.size()); end
        while (expClr.size() != 0) begin
            int e, o;
            e = expClr.pop_front();
            o = (obsClr.size() != 0) ? obsClr.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL dirty_clr: got %0d want %0d", o, e); end
        end
        compared++;
        if (obsDone.size() != 1 || obsDone[0] != expDone[0]) begin
            mismatched++;
            $display("FAIL dirty_done: got %0d pulses first=%0d want 1 at %0d", obsDone.size(),
                     (obsDone.size() != 0) ? obsDone[0] : -1, expDone[0]);
        end
        compared++;
        if (dirtyMem[2] !== 2'b00) begin mismatched++; $display("FAIL dirty_bit: got %b want 00", dirtyMem[2]); end
    endtask

    task automatic test_invalidate();
        bit ok;
        clear_queues();
        set_mem('1, '0);
        ackDelay = 3;
        expect_walk(1'b1, ackDelay);
        start_flush(1'b1);
        wait_idle(200, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL inv_timeout: busy=%b want 0", bus.FlushBusy); end
        while (expClr.size() != 0) begin
            int e, o;
            e = expClr.pop_front();
            o = (obsClr.size() != 0) ? obsClr.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL inv_clr: got %0d want %0d", o, e); end
        end
        compared++;
        if (obsClr.size() != 0) begin mismatched++; $display("FAIL inv_clr_extra: got %0d extra", obsClr.size()); end
        compared++;
        if (obsDone.size() != 1 || obsDone[0] != expDone[0]) begin
            mismatched++;
            $display("FAIL inv_done: got %0d pulses first=%0d want 1 at %0d", obsDone.size(),
                     (obsDone.size() != 0) ? obsDone[0] : -1, expDone[0]);
        end
    endtask

    task automatic test_abort_wb();
        bit ok, seen;
        clear_queues();
        set_mem('1, '0);
        dirtyMem[1] = 2'b01;
        ackDelay = 3;
        expVisit = '{1, 2, 5};
        expWb = '{5, 5, 5};
        expClr = '{37};
        start_flush(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.WriteBackReq) seen = 1'b1;
            else @(negedge clk);
        end
        compared++;
        if (!seen) begin mismatched++; $display("FAIL abortwb_req: got no WriteBackReq want one"); end
        bus.FlushAbort = 1'b1;
        @(negedge clk);
        bus.FlushAbort = 1'b0;
        wait_idle(50, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL abortwb_timeout: busy=%b want 0", bus.FlushBusy); end
        while (expVisit.size() != 0) begin
            int e, o;
            e = expVisit.pop_front();
            o = (obsVisit.size() != 0) ? obsVisit.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL abortwb_visit: got %0d want %0d", o, e); end
        end
        while (expWb.size() != 0) begin
            int e, o;
            e = expWb.pop_front();
            o = (obsWb.size() != 0) ? obsWb.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL abortwb_wb: got %0d want %0d", o, e); end
        end
        while (expClr.size() != 0) begin
            int e, o;
            e = expClr.pop_front();
            o = (obsClr.size() != 0) ? obsClr.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL abortwb_clr: got %0d want %0d", o, e); end
        end
        repeat (3) @(negedge clk);
        compared++;
        if (obsVisit.size() != 0 || obsDone.size() != 0 || bus.FlushBusy !== 1'b0) begin
            mismatched++;
            $display("FAIL abortwb_end: got visits=%0d done=%0d busy=%b want 0 0 0",
                     obsVisit.size(), obsDone.size(), bus.FlushBusy);
        end
    endtask

    task automatic test_abort_check();
        clear_queues();
        set_mem('1, '0);
        dirtyMem[0] = 2'b01;
        ackDelay = 3;
        start_flush(1'b0);
        compared++;
        if (bus.FlushAdrSel !== 1'b1) begin mismatched++; $display("FAIL abortchk_read: got sel=%b want 1", bus.FlushAdrSel); end
        @(negedge clk);
        bus.FlushAbort = 1'b1;
        @(negedge clk);
        bus.FlushAbort = 1'b0;
        compared++;
        if (bus.FlushBusy !== 1'b0) begin mismatched++; $display("FAIL abortchk_idle: got busy=%b want 0", bus.FlushBusy); end
        repeat (4) @(negedge clk);
        compared++;
        if (obsWb.size() != 0 || obsDone.size() != 0 || obsVisit.size() != 1) begin
            mismatched++;
            $display("FAIL abortchk_events: got wb=%0d done=%0d visits=%0d want 0 0 1",
                     obsWb.size(), obsDone.size(), obsVisit.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_queues();
        set_mem('1, '0);
        ackDelay = 3;
        expect_walk(1'b0, ackDelay);
        start_flush(1'b0);
        repeat (5) @(negedge clk);
        bus.FlushCache = 1'b1;
        bus.FlushInvalidate = 1'b1;
        @(negedge clk);
        bus.FlushCache = 1'b0;
        bus.FlushInvalidate = 1'b0;
        wait_idle(200, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL repulse_timeout: busy=%b want 0", bus.FlushBusy); end
        while (expVisit.size() != 0) begin
            int e, o;
            e = expVisit.pop_front();
            o = (obsVisit.size() != 0) ? obsVisit.pop_front() : -1;
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL repulse_visit: got %0d want %0d", o, e); end
        end
        compared++;
        if (obsClr.size() != 0) begin mismatched++; $display("FAIL repulse_clr: got %0d clears want 0", obsClr.size()); end
        compared++;
        if (obsDone.size() != 1 || obsDone[0] != expDone[0]) begin
            mismatched++;
            $display("FAIL repulse_done: got %0d pulses first=%0d want 1 at %0d", obsDone.size(),
                     (obsDone.size() != 0) ? obsDone[0] : -1, expDone[0]);
        end
    endtask

    task automatic test_async_reset();
        bit ok, seen;
        clear_queues();
        set_mem('1, '0);
        dirtyMem[2] = 2'b10;
        ackDelay = 0;
        start_flush(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.WriteBackReq) seen = 1'b1;
            else @(negedge clk);
        end
        compared++;
        if (!seen) begin mismatched++; $display("FAIL arst_req: got no WriteBackReq want one"); end
        repeat (2) @(negedge clk);
        compared++;
        if (bus.WriteBackReq !== 1'b1 || bus.FlushAdr !== 2'd2 || bus.FlushWay !== 2'b10) begin
            mismatched++;
            $display("FAIL arst_hold: got req=%b adr=%0d way=%b want 1 2 10",
                     bus.WriteBackReq, bus.FlushAdr, bus.FlushWay);
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({bus.FlushAdrSel, bus.WriteBackReq, bus.ClearDirty, bus.ClearValid, bus.FlushBusy,
             bus.FlushDone, bus.FlushAdr, bus.FlushWay} !== 10'b000000_00_01) begin
            mismatched++;
            $display("FAIL arst_outputs: got %b want 0000000001", {bus.FlushAdrSel, bus.WriteBackReq,
                     bus.ClearDirty, bus.ClearValid, bus.FlushBusy, bus.FlushDone, bus.FlushAdr, bus.FlushWay});
        end
        @(negedge clk);
        reset = 1'b0;
        clear_queues();
        set_mem('1, '0);
        ackDelay = 3;
        expect_walk(1'b0, ackDelay);
        start_flush(1'b0);
        wait_idle(200, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL arst_timeout: busy=%b want 0", bus.FlushBusy); end
        compared++;
        if (obsVisit.size() == 0 || obsVisit[0] != 1) begin
            mismatched++;
            $display("FAIL arst_restart: got first visit %0d want 1", (obsVisit.size() != 0) ? obsVisit[0] : -1);
        end
        compared++;
        if (obsDone.size() != 1 || obsDone[0] != expDone[0]) begin
            mismatched++;
            $display("FAIL arst_done: got %0d pulses first=%0d want 1 at %0d", obsDone.size(),
                     (obsDone.size() != 0) ? obsDone[0] : -1, expDone[0]);
        end
    endtask

    initial begin
        test_reset();
        test_clean_walk();
        test_dirty_wb();
        test_invalidate();
        test_abort_wb();
        test_abort_check();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cache_flush_walker.md
Name: cache_flush_walker

Overview:
- Sequencer that walks every set and way of a set-associative cache on a flush or invalidate command.
- Writes back dirty lines over the bus handshake, then clears their dirty (and optionally valid) bits.
- Sits beside the cache's replacement-policy block and drives the cache address-select mux while active.
- Shares the cache's NUMWAYS, SETLEN and NUMLINES configuration.

Parameters:
- NUMWAYS, 4, associativity; power of 2, ≥2.
- NUMLINES, 128, number of sets; power of 2.
- SETLEN, 7, set-index width; must equal $clog2(NUMLINES).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- FlushCache  in  1  start pulse: write back all dirty lines
- FlushInvalidate  in  1  sampled with FlushCache; also clear valid bits of every valid line visited
- FlushAbort  in  1  cancel walk (trap/flush of requesting stage)
- ValidWay  in  NUMWAYS  valid bits of set FlushAdr, available one cycle after the address
- DirtyWay  in  NUMWAYS  dirty bits of set FlushAdr, same timing as ValidWay
- WriteBackAck  in  1  bus accepted the writeback
- FlushAdrSel  out  1  cache set-address mux selects FlushAdr
- FlushAdr  out  SETLEN  current set index
- FlushWay  out  NUMWAYS  one-hot current way
- WriteBackReq  out  1  request writeback of the line at FlushAdr/FlushWay
- ClearDirty  out  1  clear dirty bit at FlushAdr/FlushWay this cycle
- ClearValid  out  1  clear valid bit at FlushAdr/FlushWay this cycle
- FlushBusy  out  1  walk in progress
- FlushDone  out  1  one-cycle completion pulse

Behaviour:
- Reset values: state IDLE, FlushAdr=0, FlushWay=1 (way 0), FlushAdrSel/WriteBackReq/ClearDirty/ClearValid/FlushBusy/FlushDone=0. Reset mid-walk abandons the walk immediately, including any outstanding WriteBackReq.
- States: IDLE, READ, CHECK, WB, CLEAR, DONE.
- IDLE: on FlushCache, capture FlushInvalidate into InvMode, set FlushAdr=0 and FlushWay=1, go to READ. FlushCache in any other state is ignored.
- READ: FlushAdrSel=1; the arrays read the set. Go to CHECK.
- CHECK: let D = |(DirtyWay & FlushWay) and V = |(ValidWay & FlushWay).
  - If D: go to WB.
  - Else if InvMode and V: go to CLEAR.
  - Else: advance.
- WB: WriteBackReq=1, held stable (address and way unchanged) until WriteBackAck. Ack in the first WB cycle is legal. On ack, go to CLEAR.
- CLEAR (1 cycle): ClearDirty=1 if the line was dirty; ClearValid=InvMode. Then advance.
- Advance:
  - If FlushWay is the last way and FlushAdr=NUMLINES-1, go to DONE.
  - Else rotate FlushWay left; on wrap to way 0, increment FlushAdr. Go to READ.
- DONE: FlushDone=1 for one cycle, then IDLE.
- FlushBusy=1 in every state except IDLE. FlushAdrSel=1 in READ, CHECK, WB and CLEAR.
- FlushAbort:
  - In READ or CHECK: go to IDLE next cycle with no FlushDone.
  - In WB: latch the abort; finish the handshake and the CLEAR, then go to IDLE with no FlushDone. A bus transaction is never dropped.
  - In DONE: ignored.
- Latency for a clean cache with InvMode=0: FlushDone is high exactly 2·NUMLINES·NUMWAYS cycles after the edge that sampled FlushCache.
  - Each dirty line adds (WB cycles) + 1.
  - In InvMode, each valid clean line adds 1.
- Counters: FlushAdr is SETLEN bits; way index is $clog2(NUMWAYS) bits, decoded to one-hot. There is no wrap past the final set; the last-line flag terminates the walk.

Decomposition:
- Shared package cache_flush_pkg: typedef enum logic [2:0] flushstate_t {IDLE, READ, CHECK, WB, CLEAR, DONE}.
- Sub-module flush_counter #(NUMWAYS, SETLEN):
  - Inputs: clk, reset, init, advance.
  - Outputs: set index, way index, last flag.
  - Top level holds the FSM and the one-hot decode, reusing the existing decoder.

Test Plan:
- NUMLINES=4, NUMWAYS=2, all clean, FlushCache pulse → FlushAdr/FlushWay visit (0,01),(0,10),(1,01)…(3,10); FlushDone high exactly 16 cycles after the start edge; no WriteBackReq.
- Set 2 way 1 dirty, WriteBackAck delayed 3 cycles → WriteBackReq held with FlushAdr=2, FlushWay=10 for 3 cycles; ClearDirty 1 cycle after ack; FlushDone at cycle 16+3+1=20.
- FlushInvalidate=1, all lines valid, all clean → ClearValid pulses 8 times with ClearDirty=0; FlushDone at cycle 24.
- FlushAbort during WB at set 1 → WriteBackReq held until ack; one CLEAR; then IDLE with FlushBusy=0 and no FlushDone. FlushAbort in CHECK → IDLE next cycle.
- FlushCache re-pulsed mid-walk → ignored; the walk order and FlushDone timing are unchanged.
- Async reset asserted while WriteBackReq=1 → all outputs 0 and FlushWay=01 without a clock edge; a new FlushCache after release restarts from set 0.
